// File: rtl/rom_burst_pair_reader.sv
// Burst read sequencer that drives both address ports of a dual-port ROM and streams word pairs out through a 2-entry skid FIFO.
// Optional macro ROM_READER_ABORT_EN adds an abort_i input that flushes and ends the running burst.
module rom_burst_pair_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_base_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    output logic [ADDR_WIDTH-1:0]   rom_addr_a_o,
    output logic [ADDR_WIDTH-1:0]   rom_addr_b_o,
    input  logic [DATA_WIDTH-1:0]   rom_q_a_i,
    input  logic [DATA_WIDTH-1:0]   rom_q_b_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [2*DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]              out_keep_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef ROM_READER_ABORT_EN
    ,
    input  logic                    abort_i
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic                    inflight_q;
    logic [1:0]              tag_keep_q;
    logic                    tag_last_q;
    logic                    cmd_ready_q;
    logic                    busy_q;
    logic                    done_q;

    logic [2*DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [1:0]              head_keep_q, head_keep_d, tail_keep_q, tail_keep_d;
    logic                    head_last_q, head_last_d, tail_last_q, tail_last_d;
    logic                    head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

    logic                    abort_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    issue_s;
    logic [1:0]              occ_s;
    logic                    pair_last_s;
    logic [1:0]              pair_keep_s;
    logic [LEN_WIDTH-1:0]    rem_next_s;

`ifdef ROM_READER_ABORT_EN
    assign abort_s = abort_i && (state_q != S_IDLE);
`else
    assign abort_s = 1'b0;
`endif

    // Occupancy counts the pair still in the ROM pipeline so the FIFO can never overflow.
    assign occ_s       = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, inflight_q};
    assign pop_s       = head_vld_q && out_ready_i;
    assign push_s      = inflight_q && !abort_s;
    assign issue_s     = (state_q == S_FETCH) && !abort_s && ((occ_s < 2'd2) || pop_s);
    assign pair_keep_s = (rem_q == LEN_WIDTH'(1)) ? 2'b01 : 2'b11;
    assign pair_last_s = (rem_q <= LEN_WIDTH'(2));
    assign rem_next_s  = (rem_q >= LEN_WIDTH'(2)) ? (rem_q - LEN_WIDTH'(2)) : {LEN_WIDTH{1'b0}};

    assign rom_addr_a_o = ptr_q;
    assign rom_addr_b_o = ptr_q + ADDR_WIDTH'(1);
    assign cmd_ready_o  = cmd_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign out_valid_o  = head_vld_q;
    assign out_data_o   = head_data_q;
    assign out_keep_o   = head_keep_q;
    assign out_last_o   = head_last_q;

    // Sequencer: command capture, pair issue, state transitions and done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= {ADDR_WIDTH{1'b0}};
            rem_q       <= {LEN_WIDTH{1'b0}};
            inflight_q  <= 1'b0;
            tag_keep_q  <= 2'b00;
            tag_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue_s;
            if (issue_s) begin
                tag_keep_q <= pair_keep_s;
                tag_last_q <= pair_last_s;
                ptr_q      <= ptr_q + ADDR_WIDTH'(2);
                rem_q      <= rem_next_s;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        ptr_q <= cmd_base_i;
                        rem_q <= cmd_len_i;
                        if (cmd_len_i == {LEN_WIDTH{1'b0}}) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= S_FETCH;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort_s) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (issue_s && pair_last_s) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort_s || (pop_s && head_last_q)) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Skid FIFO next state: head entry drives the output stream directly, tail absorbs one stall.
    always_comb begin
        head_data_d = head_data_q;
        head_keep_d = head_keep_q;
        head_last_d = head_last_q;
        head_vld_d  = head_vld_q;
        tail_data_d = tail_data_q;
        tail_keep_d = tail_keep_q;
        tail_last_d = tail_last_q;
        tail_vld_d  = tail_vld_q;
        if (abort_s) begin
            head_keep_d = 2'b00;
            head_last_d = 1'b0;
            head_vld_d  = 1'b0;
            tail_keep_d = 2'b00;
            tail_last_d = 1'b0;
            tail_vld_d  = 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (tail_vld_q) begin
                        head_data_d = tail_data_q;
                        head_keep_d = tail_keep_q;
                        head_last_d = tail_last_q;
                        tail_data_d = {rom_q_b_i, rom_q_a_i};
                        tail_keep_d = tag_keep_q;
                        tail_last_d = tag_last_q;
                    end else begin
                        head_data_d = {rom_q_b_i, rom_q_a_i};
                        head_keep_d = tag_keep_q;
                        head_last_d = tag_last_q;
                    end
                end
                2'b10: begin
                    if (head_vld_q) begin
                        tail_data_d = {rom_q_b_i, rom_q_a_i};
                        tail_keep_d = tag_keep_q;
                        tail_last_d = tag_last_q;
                        tail_vld_d  = 1'b1;
                    end else begin
                        head_data_d = {rom_q_b_i, rom_q_a_i};
                        head_keep_d = tag_keep_q;
                        head_last_d = tag_last_q;
                        head_vld_d  = 1'b1;
                    end
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_keep_d = tail_keep_q;
                    head_last_d = tail_last_q;
                    head_vld_d  = tail_vld_q;
                    tail_keep_d = 2'b00;
                    tail_last_d = 1'b0;
                    tail_vld_d  = 1'b0;
                end
                default: begin
                    head_vld_d = head_vld_q;
                end
            endcase
        end
    end

    // Skid FIFO storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_data_q <= {(2*DATA_WIDTH){1'b0}};
            head_keep_q <= 2'b00;
            head_last_q <= 1'b0;
            head_vld_q  <= 1'b0;
            tail_data_q <= {(2*DATA_WIDTH){1'b0}};
            tail_keep_q <= 2'b00;
            tail_last_q <= 1'b0;
            tail_vld_q  <= 1'b0;
        end else begin
            head_data_q <= head_data_d;
            head_keep_q <= head_keep_d;
            head_last_q <= head_last_d;
            head_vld_q  <= head_vld_d;
            tail_data_q <= tail_data_d;
            tail_keep_q <= tail_keep_d;
            tail_last_q <= tail_last_d;
            tail_vld_q  <= tail_vld_d;
        end
    end

endmodule

// File: tb/tb_rom_burst_pair_reader.sv
// Scoreboard bench for rom_burst_pair_reader: a ROM model, a pair-list reference model and a decoupled output monitor.
module tb_rom_burst_pair_reader;

    localparam int DW = 12;
    localparam int AW = 10;
    localparam int LW = 11;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic [1:0]      keep;
        logic            last;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic [DW-1:0] rom_q_a = '0, rom_q_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*DW-1:0] out_data;
    logic [1:0]    out_keep;
    logic          out_last;
    logic          busy, done;
`ifdef ROM_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int rdy_mode = 0;
    int rdy_phase = 0;
    bit skip_hold = 1'b0;
    pair_t exp_q[$];

    always #5 clk = ~clk;

    rom_burst_pair_reader dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
        .rom_addr_a_o(rom_addr_a), .rom_addr_b_o(rom_addr_b),
        .rom_q_a_i(rom_q_a), .rom_q_b_i(rom_q_b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_keep_o(out_keep), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
`ifdef ROM_READER_ABORT_EN
        , .abort_i(abort)
`endif
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {2'b10, a};
    endfunction

    // Registered dual-port ROM: data one cycle after the address.
    always @(posedge clk) begin
        rom_q_a <= rom_word(rom_addr_a);
        rom_q_b <= rom_word(rom_addr_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst of len words from base becomes ceil(len/2) pairs.
    task automatic model_cmd(input logic [AW-1:0] base, input int len);
        int n;
        pair_t p;
        logic [AW-1:0] a;
        n = (len + 1) / 2;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(2 * i);
            p.data = {rom_word(a + AW'(1)), rom_word(a)};
            p.keep = (len - 2 * i == 1) ? 2'b01 : 2'b11;
            p.last = (i == n - 1);
            exp_q.push_back(p);
        end
        exp_done++;
    endtask

    // Consumer ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_phase == 0);
                    rdy_phase = (rdy_phase + 1) % 3;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted pair and checks stall stability and done timing.
    logic [2*DW+2:0] prev_bus;
    bit stall_prev = 1'b0;
    bit last_pop_prev = 1'b0;
    pair_t got;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            last_pop_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (last_pop_prev) chk("done_after_last", 32'(done), 32'd1);
            last_pop_prev = 1'b0;
            if (stall_prev && !skip_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_bus", 32'({out_data, out_keep, out_last}), 32'(prev_bus));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pair: got %0h with empty scoreboard", out_data);
                end else begin
                    got = exp_q.pop_front();
                    chk("pair_data", 32'(out_data), 32'(got.data));
                    chk("pair_keep", 32'(out_keep), 32'(got.keep));
                    chk("pair_last", 32'(out_last), 32'(got.last));
                end
                if (out_last) last_pop_prev = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            prev_bus = {out_data, out_keep, out_last};
        end
    end

    task automatic send_cmd(input logic [AW-1:0] base, input int len);
        int w = 0;
        @(posedge clk);
        #1;
        while (!cmd_ready && w < 2000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
            return;
        end
        cmd_valid = 1'b1;
        cmd_base = base;
        cmd_len = LW'(len);
        @(posedge clk);
        model_cmd(base, len);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        @(negedge clk);
        #1;
        while (!(exp_q.size() == 0 && cmd_ready && !busy) && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        chk({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_keep_last"}, 32'({out_keep, out_last}), 32'd0);
        chk({name, "_busy_done"}, 32'({busy, done}), 32'd0);
        chk({name, "_addr"}, 32'({rom_addr_a, rom_addr_b}), 32'({10'h000, 10'h001}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] b;
        int l;
        #12;
        check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_rst");

        // Basic burst, latency and addressing
        rdy_mode = 0;
        send_cmd(10'h010, 6);
        @(negedge clk);
        chk("t1_c1_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h010, 10'h011}));
        chk("t1_c1_flags", 32'({cmd_ready, busy, out_valid}), 32'b010);
        @(negedge clk);
        chk("t1_c2_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h012, 10'h013}));
        chk("t1_c2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_c3_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h014, 10'h015}));
        chk("t1_c3_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t1_c4_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t1_c5_valid", 32'(out_valid), 32'd1);
        wait_idle("t1");

        // Address wrap with odd length
        send_cmd(10'h3FF, 3);
        @(negedge clk);
        chk("t2_c1_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h3FF, 10'h000}));
        @(negedge clk);
        chk("t2_c2_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h001, 10'h002}));
        wait_idle("t2");

        // Empty burst
        send_cmd(10'h123, 0);
        @(negedge clk);
        chk("t3_done", 32'({done, cmd_ready, out_valid}), 32'b110);
        @(negedge clk);
        chk("t3_after", 32'({done, cmd_ready, out_valid}), 32'b010);
        wait_idle("t3");

        // Stalled consumer
        rdy_phase = 0;
        rdy_mode = 1;
        send_cmd(10'h080, 16);
        wait_idle("t4");

        // Reset in the third FETCH cycle
        rdy_mode = 0;
        send_cmd(10'h100, 20);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_reset_vals("t5_rst");
        exp_q.delete();
        exp_done--;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t5_no_done", 32'(done_cnt), 32'(exp_done));
        send_cmd(10'h2A0, 5);
        @(negedge clk);
        chk("t5_new_addr", 32'({rom_addr_a, rom_addr_b}), 32'({10'h2A0, 10'h2A1}));
        wait_idle("t5");

`ifdef ROM_READER_ABORT_EN
        // Abort in DRAIN with two pairs buffered
        rdy_mode = 3;
        skip_hold = 1'b1;
        send_cmd(10'h040, 4);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_after", 32'({out_valid, done, cmd_ready}), 32'b011);
        @(negedge clk);
        chk("t6_single_done", 32'(done), 32'd0);
        skip_hold = 1'b0;
        rdy_mode = 0;
        wait_idle("t6");
`endif

        // Randomized bursts with a random consumer
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            b = AW'($urandom_range(0, 1023));
            if (k % 5 == 0) b = AW'(1020 + $urandom_range(0, 3));
            l = $urandom_range(0, 40);
            send_cmd(b, l);
            if (k % 3 == 0) wait_idle("rand");
        end
        wait_idle("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
